// File: rtl/alu_issuer_pkg.sv
// alu_issuer_pkg
// Shared types and constants for the ALU command issuer: the command word
// layout presented to the ALU, the issuer state encoding and a reference
// function of the ALU result used by the optional result checker.
package alu_issuer_pkg;

  localparam int DATA_W = 3;

  // Field order fixes the packed layout: op in the top bits, c in the bottom.
  typedef struct packed {
    logic [DATA_W-1:0] op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } issuer_state_t;

  // op bit that selects the compare-driven branch of the ALU.
  localparam int OP_CMP_BIT = 2;

  function automatic logic [DATA_W-1:0] alu_ref(input alu_cmd_t cmd);
    if (cmd.op[OP_CMP_BIT]) begin
      if (cmd.a > cmd.b) return cmd.b + cmd.c;  // wraps modulo 2**DATA_W
      return cmd.b | cmd.c;
    end
    return ~cmd.c;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
// Synchronous FIFO for issuer commands. Data storage is not reset; only the
// pointers and occupancy count are. Pushes while full and pops while empty
// are ignored.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write strobe and data
//   pop, dout       read strobe and head-of-queue data (valid when !empty)
//   full, empty     occupancy flags
//   count           entries held, 0..DEPTH
module alu_cmd_fifo
  import alu_issuer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Buffers {op,a,b,c} commands, presents one at a time on registered alu_*
// outputs, holds them for SETTLE_CYCLES, captures alu_r and returns it on a
// valid/ready response channel. Commands complete strictly in order.
// Optional result checker: define ALU_ISSUER_CHECK_EN to build a reference
// model that raises the sticky mismatch flag when alu_r disagrees with it;
// otherwise mismatch is tied low.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_a, cmd_b, cmd_c      command fields
//   alu_op, alu_a, alu_b, alu_c      registered operands to the ALU
//   alu_r                            ALU result
//   rsp_valid/rsp_ready, rsp_r       response handshake and captured result
//   busy                             work in flight or queued
//   mismatch                         sticky checker flag
module alu_cmd_issuer
  import alu_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_c,
  output logic [DATA_W-1:0] alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_c,
  input  logic [DATA_W-1:0] alu_r,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_r,
  output logic              busy,
  output logic              mismatch
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] DEPTH_CNT   = FCNT_W'(FIFO_DEPTH);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);

  issuer_state_t     state_q;
  alu_cmd_t          alu_q;
  logic [SCNT_W-1:0] settle_cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_r_q;

  alu_cmd_t          cmd_in;
  alu_cmd_t          fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic              capture;

  assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, c: cmd_c};

  // Ready depends only on occupancy, so a pop in a full cycle does not open
  // a slot for a push until the following cycle.
  assign cmd_ready = (fifo_count < DEPTH_CNT);
  assign fifo_push = cmd_valid && !fifo_full;

  // Pop whenever the FSM is about to load a new command: from IDLE, or from
  // RESP on the handshake cycle (back-to-back issue).
  assign fifo_pop = !fifo_empty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

  assign capture = (state_q == ST_DRIVE) && (settle_cnt_q == SETTLE_LAST);

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_q        <= '0;
      settle_cnt_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_r_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_q        <= fifo_head;
            settle_cnt_q <= '0;
            state_q      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (capture) begin
            rsp_r_q     <= alu_r;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!fifo_empty) begin
              alu_q        <= fifo_head;
              settle_cnt_q <= '0;
              state_q      <= ST_DRIVE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_op    = alu_q.op;
  assign alu_a     = alu_q.a;
  assign alu_b     = alu_q.b;
  assign alu_c     = alu_q.c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

`ifdef ALU_ISSUER_CHECK_EN
  logic mismatch_q;

  // Compared on the same cycle alu_r is captured; sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (capture && (alu_r != alu_ref(alu_q))) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule
